// File: rtl/mem_access_sequencer.sv
// Byte-serial memory access sequencer.
// Receives a command frame over a byte stream, stalls the CPU pipeline, issues a
// single instruction/data memory request, and returns an ack, read data or an
// error byte over a handshaked byte stream.
module mem_access_sequencer #(
  parameter int unsigned RX_TIMEOUT = 50000,
  parameter int unsigned RSP_WAIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  output logic        cpu_enable,
  output logic        write_mem_req,
  output logic        rw_flag,
  output logic        target_mem_type,
  output logic [8:0]  target_addr,
  output logic [31:0] wr_data,
  input  logic        instr_rsp_ready,
  input  logic [41:0] instr_rsp_data,
  input  logic        data_rsp_ready,
  input  logic [41:0] data_rsp_data,
  output logic        busy
);

  localparam int unsigned GAP_W  = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned WAIT_W = $clog2(RSP_WAIT + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RX_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RSP_WAIT - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] HALT     = 3'd3;
  localparam logic [2:0] ISSUE    = 3'd4;
  localparam logic [2:0] WAIT_RSP = 3'd5;
  localparam logic [2:0] SEND     = 3'd6;

  // What the SEND state is transmitting
  localparam logic [1:0] TX_ACK = 2'd0;
  localparam logic [1:0] TX_ERR = 2'd1;
  localparam logic [1:0] TX_RSP = 2'd2;

  logic [2:0]        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [1:0]        byte_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [41:0]       rsp_q;
  logic [1:0]        tx_kind;
  logic [2:0]        tx_idx;
  logic              tx_last;
  logic              sel_ready;
  logic [41:0]       sel_data;

  // Only the response port matching the latched memory type is observed
  assign sel_ready = target_mem_type ? instr_rsp_ready : data_rsp_ready;
  assign sel_data  = target_mem_type ? instr_rsp_data  : data_rsp_data;
  assign tx_last   = (tx_kind != TX_RSP) || (tx_idx == 3'd5);

  // Frame reception, request sequencing and transmit progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rw_flag         <= 1'b0;
      target_mem_type <= 1'b0;
      target_addr     <= '0;
      wr_data         <= '0;
      gap_cnt         <= '0;
      byte_cnt        <= '0;
      wait_cnt        <= '0;
      rsp_q           <= '0;
      tx_kind         <= TX_ACK;
      tx_idx          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            rw_flag         <= rx_byte[7];
            target_mem_type <= rx_byte[6];
            target_addr[8]  <= rx_byte[0];
            gap_cnt         <= '0;
            state           <= ADDR;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            target_addr[7:0] <= rx_byte;
            gap_cnt          <= '0;
            byte_cnt         <= '0;
            state            <= rw_flag ? DATA : HALT;
          end else if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            wr_data  <= {wr_data[23:0], rx_byte};
            gap_cnt  <= '0;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) state <= HALT;
          end else if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        HALT: state <= ISSUE;
        ISSUE: begin
          wait_cnt <= '0;
          tx_idx   <= '0;
          tx_kind  <= TX_ACK;
          state    <= rw_flag ? SEND : WAIT_RSP;
        end
        WAIT_RSP: begin
          if (sel_ready) begin
            rsp_q   <= sel_data;
            tx_kind <= TX_RSP;
            state   <= SEND;
          end else if (wait_cnt == WAIT_LAST) begin
            tx_kind <= TX_ERR;
            state   <= SEND;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (tx_last) state <= IDLE;
            else         tx_idx <= tx_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // State-decoded outputs so reset takes effect without waiting for a clock
  always_comb begin
    busy          = (state != IDLE);
    cpu_enable    = (state == IDLE) || (state == ADDR) || (state == DATA);
    write_mem_req = (state == ISSUE);
    tx_valid      = (state == SEND);
  end

  // Transmit byte mux; zero outside SEND
  always_comb begin
    tx_byte = 8'h00;
    if (state == SEND) begin
      case (tx_kind)
        TX_ACK: tx_byte = 8'hA5;
        TX_ERR: tx_byte = 8'hEE;
        default: begin
          case (tx_idx)
            3'd0:    tx_byte = {6'b0, rsp_q[41:40]};
            3'd1:    tx_byte = rsp_q[39:32];
            3'd2:    tx_byte = rsp_q[31:24];
            3'd3:    tx_byte = rsp_q[23:16];
            3'd4:    tx_byte = rsp_q[15:8];
            3'd5:    tx_byte = rsp_q[7:0];
            default: tx_byte = 8'h00;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: the stimulus pushes expected memory
// requests and tx bytes into queues; a negedge monitor pops and compares them.
module tb_mem_access_sequencer;

  localparam int unsigned T = 16;  // RX_TIMEOUT used for this bench

  logic        clk, reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        cpu_enable, write_mem_req, rw_flag, target_mem_type, busy;
  logic [8:0]  target_addr;
  logic [31:0] wr_data;
  logic        instr_rsp_ready, data_rsp_ready;
  logic [41:0] instr_rsp_data, data_rsp_data;

  mem_access_sequencer #(.RX_TIMEOUT(T), .RSP_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .cpu_enable(cpu_enable), .write_mem_req(write_mem_req), .rw_flag(rw_flag),
    .target_mem_type(target_mem_type), .target_addr(target_addr), .wr_data(wr_data),
    .instr_rsp_ready(instr_rsp_ready), .instr_rsp_data(instr_rsp_data),
    .data_rsp_ready(data_rsp_ready), .data_rsp_data(data_rsp_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        typ;
    logic [8:0]  addr;
    logic [31:0] data;
    logic        chk_data;
  } req_t;

  req_t       exp_req[$];
  logic [7:0] exp_tx[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen/missing contrary to expectation", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic push_req(input logic rw, input logic typ, input logic [8:0] addr,
                          input logic [31:0] data, input logic chk_data);
    req_t r;
    r.rw = rw; r.typ = typ; r.addr = addr; r.data = data; r.chk_data = chk_data;
    exp_req.push_back(r);
  endtask

  task automatic push_rsp(input logic [41:0] d);
    exp_tx.push_back({6'b0, d[41:40]});
    exp_tx.push_back(d[39:32]);
    exp_tx.push_back(d[31:24]);
    exp_tx.push_back(d[23:16]);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
  endtask

  // Returns in the cycle write_mem_req is high
  task automatic wait_req();
    int n = 0;
    while (!write_mem_req && n < 50) begin
      step();
      n++;
    end
    if (!write_mem_req) fail("wait_req_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // Pulse a response port d cycles after the request cycle
  task automatic rsp_pulse(input logic instr_port, input int d, input logic [41:0] data);
    wait_req();
    repeat (d) step();
    if (instr_port) begin
      instr_rsp_ready = 1'b1; instr_rsp_data = data;
    end else begin
      data_rsp_ready = 1'b1; data_rsp_data = data;
    end
    step();
    instr_rsp_ready = 1'b0;
    data_rsp_ready  = 1'b0;
  endtask

  // Monitor: compare every request and tx handshake against the queues
  logic prev_cpu_en = 1'b1;
  logic prev_req = 1'b0;
  req_t mr;
  always @(negedge clk) begin
    if (reset) begin
      prev_cpu_en = 1'b1;
      prev_req    = 1'b0;
    end else begin
      if (write_mem_req) begin
        if (exp_req.size() == 0) begin
          fail("req_unexpected");
        end else begin
          mr = exp_req.pop_front();
          chk("req_rw", rw_flag, mr.rw);
          chk("req_type", target_mem_type, mr.typ);
          chk("req_addr", target_addr, mr.addr);
          if (mr.chk_data) chk("req_wr_data", wr_data, mr.data);
          chk("req_cpu_en_prev_cycle", prev_cpu_en, 0);
          chk("req_cpu_en", cpu_enable, 0);
          chk("req_single_cycle", prev_req, 0);
        end
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) fail("tx_unexpected");
        else chk("tx_byte", tx_byte, exp_tx.pop_front());
      end
      prev_cpu_en = cpu_enable;
      prev_req    = write_mem_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1;
    instr_rsp_ready = 1'b0; data_rsp_ready = 1'b0;
    instr_rsp_data = '0; data_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_enable", cpu_enable, 1);
    chk("rst_write_mem_req", write_mem_req, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fields", {rw_flag, target_mem_type, target_addr, wr_data}, 0);
    reset = 1'b0;
    step();

    // Write frame: rw=1 type=1 addr=0x005 data=0x00900113 -> ack A5
    push_req(1'b1, 1'b1, 9'h005, 32'h0090_0113, 1'b1);
    exp_tx.push_back(8'hA5);
    send_byte(8'hC0); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h90); send_byte(8'h01); send_byte(8'h13);
    wait_idle();
    chk("write_cpu_en_back", cpu_enable, 1);

    // Data read (header 0x01: rw=0 type=0 addr8=1), ready in first wait cycle
    push_req(1'b0, 1'b0, 9'h102, 32'h0, 1'b0);
    push_rsp(42'h3_0211_2233_44);
    send_byte(8'h01); send_byte(8'h02);
    rsp_pulse(1'b0, 1, 42'h3_0211_2233_44);
    n = 0;
    while (tx_valid && n < 20) begin
      n++;
      step();
    end
    chk("burst_len_no_bubble", n, 6);
    chk("read_cpu_en_back", cpu_enable, 1);

    // Instruction read (header 0x41: type=1), ready in the last allowed wait cycle
    push_req(1'b0, 1'b1, 9'h17F, 32'h0, 1'b0);
    push_rsp(42'h2_DEAD_BEEF_01);
    send_byte(8'h41); send_byte(8'h7F);
    rsp_pulse(1'b1, 4, 42'h2_DEAD_BEEF_01);
    wait_idle();

    // Data read with only the instruction ready toggling -> error byte after 4 cycles
    push_req(1'b0, 1'b0, 9'h010, 32'h0, 1'b0);
    exp_tx.push_back(8'hEE);
    send_byte(8'h00); send_byte(8'h10);
    wait_req();
    step();
    instr_rsp_ready = 1'b1; instr_rsp_data = 42'h3_FFFF_FFFF_FF;
    step(); step();
    instr_rsp_ready = 1'b0;
    step();
    chk("err_not_yet", tx_valid, 0);
    step();
    chk("err_tx_valid", tx_valid, 1);
    chk("err_tx_byte", tx_byte, 8'hEE);
    wait_idle();

    // Instruction read with only the data ready pulsed -> error byte
    push_req(1'b0, 1'b1, 9'h010, 32'h0, 1'b0);
    exp_tx.push_back(8'hEE);
    send_byte(8'h40); send_byte(8'h10);
    rsp_pulse(1'b0, 1, 42'h1_1111_1111_11);
    wait_idle();

    // Header then silence: abort exactly after T idle cycles
    send_byte(8'hC0);
    repeat (T - 1) step();
    chk("timeout_busy_before", busy, 1);
    step();
    chk("timeout_busy_after", busy, 0);
    chk("timeout_cpu_en", cpu_enable, 1);

    // Write with maximal byte gaps still succeeds
    push_req(1'b1, 1'b0, 9'h1FF, 32'hDEAD_BEEF, 1'b1);
    exp_tx.push_back(8'hA5);
    send_byte(8'h81);
    repeat (T - 1) step();
    send_byte(8'hFF);
    repeat (T - 1) step();
    send_byte(8'hDE); send_byte(8'hAD);
    repeat (T - 1) step();
    send_byte(8'hBE); send_byte(8'hEF);
    wait_idle();

    // Backpressure during SEND with rx bytes injected
    tx_ready = 1'b0;
    push_req(1'b0, 1'b0, 9'h033, 32'h0, 1'b0);
    push_rsp(42'h1_A1B2_C3D4_E5);
    send_byte(8'h00); send_byte(8'h33);
    rsp_pulse(1'b0, 2, 42'h1_A1B2_C3D4_E5);
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'hC1 ^ 8'(i);
      chk("stall_tx_valid", tx_valid, 1);
      chk("stall_tx_byte", tx_byte, 8'h01);
      step();
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wait_idle();
    repeat (3) step();
    chk("stall_no_extra_frame", busy, 0);

    // Reset during WAIT_RSP
    push_req(1'b0, 1'b0, 9'h020, 32'h0, 1'b0);
    send_byte(8'h00); send_byte(8'h20);
    wait_req();
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_cpu_en", cpu_enable, 1);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", target_addr, 0);
    step();
    reset = 1'b0;
    data_rsp_ready = 1'b1; data_rsp_data = 42'h0_1234_5678_9A;
    n = 0;
    repeat (12) begin
      if (tx_valid || write_mem_req) n++;
      step();
    end
    data_rsp_ready = 1'b0;
    chk("post_rst_quiet", n, 0);

    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("req_queue_drained", exp_req.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
